// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback port scheduler.
package wb_pkg;

    localparam int         WB_DEPTH = 4;
    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Long-op result queue: one push, zero to two pops per cycle, exposes head and head+1.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          push,
    input  wb_entry_t                     push_entry,
    input  logic [1:0]                    pop_cnt,
    output wb_entry_t                     head_entry,
    output wb_entry_t                     next_entry,
    output logic [$clog2(DEPTH):0]        count,
    output logic [DEPTH-1:0]              valid,
    output logic [DEPTH-1:0][4:0]         rd_all
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wb_entry_t         mem [DEPTH];
    logic [PW-1:0]     head_ptr;
    logic [PW-1:0]     tail_ptr;
    logic [PW-1:0]     next_ptr;
    logic [DEPTH-1:0]  valid_nxt;

    assign next_ptr   = head_ptr + PW'(1);
    assign head_entry = mem[head_ptr];
    assign next_entry = mem[next_ptr];

    always_comb begin
        // NOTE: every comb output gets a default first, so no path leaves it unassigned (no latch).
        valid_nxt = valid;
        if (pop_cnt != 2'd0) valid_nxt[head_ptr] = 1'b0;
        if (pop_cnt == 2'd2) valid_nxt[next_ptr] = 1'b0;
        if (push)            valid_nxt[tail_ptr] = 1'b1;
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
            valid    <= '0;
        end else begin
            head_ptr <= head_ptr + PW'(pop_cnt);
            tail_ptr <= tail_ptr + PW'(push);
            count    <= count + CW'(push) - CW'(pop_cnt);
            valid    <= valid_nxt;
        end
    end

    // NOTE: payload storage is not reset; the valid bits alone decide what is live.
    always_ff @(posedge clk) begin
        if (push) mem[tail_ptr] <= push_entry;
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) rd_all[i] = mem[i].rd;
    end

endmodule

// File: rtl/wb_port_scheduler.sv
// Merges dual-issue writeback lanes with queued mul/div results onto the two register-file ports.
module wb_port_scheduler
    import wb_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   RegWriteInA,
    input  logic [4:0]             WriteRegInA,
    input  logic [31:0]            ResultInA,
    input  logic                   RegWriteInB,
    input  logic [4:0]             WriteRegInB,
    input  logic [31:0]            ResultInB,
    input  logic                   LongValid,
    output logic                   LongReady,
    input  logic [4:0]             LongReg,
    input  logic [31:0]            LongData,
    output logic                   RegWriteOutA,
    output logic [4:0]             WriteRegOutA,
    output logic [31:0]            ResultOutA,
    output logic                   RegWriteOutB,
    output logic [4:0]             WriteRegOutB,
    output logic [31:0]            ResultOutB,
    output logic [31:0]            PendingMask,
    output logic [$clog2(DEPTH):0] PendingCount
);

    localparam int CW = $clog2(DEPTH) + 1;

    wb_entry_t             head_entry;
    wb_entry_t             next_entry;
    wb_entry_t             b_entry;
    logic [CW-1:0]         count;
    logic [DEPTH-1:0]      valid;
    logic [DEPTH-1:0][4:0] rd_all;
    logic                  lane_a_ok;
    logic                  lane_b_ok;
    logic                  fill_a;
    logic                  fill_b;
    logic [1:0]            pop_cnt;
    logic                  push;

    assign LongReady    = !reset && (count < CW'(DEPTH));
    assign push         = LongValid && LongReady;
    assign PendingCount = count;

    // Same-register lane collision: the younger lane B wins.
    assign lane_b_ok = RegWriteInB && (WriteRegInB != REG_ZERO);
    assign lane_a_ok = RegWriteInA && (WriteRegInA != REG_ZERO)
                       && !(lane_b_ok && (WriteRegInB == WriteRegInA));

    // Free ports take the queue in order: head to the first free port, head+1 only to B.
    assign fill_a  = !lane_a_ok && (count != '0);
    assign fill_b  = !lane_b_ok && (fill_a ? (count >= CW'(2)) : (count != '0));
    assign b_entry = fill_a ? next_entry : head_entry;
    assign pop_cnt = {1'b0, fill_a} + {1'b0, fill_b};

    always_comb begin
        RegWriteOutA = 1'b0;
        WriteRegOutA = '0;
        ResultOutA   = '0;
        RegWriteOutB = 1'b0;
        WriteRegOutB = '0;
        ResultOutB   = '0;
        if (lane_a_ok) begin
            RegWriteOutA = 1'b1;
            WriteRegOutA = WriteRegInA;
            ResultOutA   = ResultInA;
        end else if (fill_a) begin
            RegWriteOutA = head_entry.rd != REG_ZERO;
            WriteRegOutA = head_entry.rd;
            ResultOutA   = head_entry.data;
        end
        if (lane_b_ok) begin
            RegWriteOutB = 1'b1;
            WriteRegOutB = WriteRegInB;
            ResultOutB   = ResultInB;
        end else if (fill_b) begin
            RegWriteOutB = b_entry.rd != REG_ZERO;
            WriteRegOutB = b_entry.rd;
            ResultOutB   = b_entry.data;
        end
        if (reset) begin
            RegWriteOutA = 1'b0;
            RegWriteOutB = 1'b0;
        end
    end

    always_comb begin
        PendingMask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i]) PendingMask[rd_all[i]] = 1'b1;
        end
    end

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .push_entry ('{rd: LongReg, data: LongData}),
        .pop_cnt    (pop_cnt),
        .head_entry (head_entry),
        .next_entry (next_entry),
        .count      (count),
        .valid      (valid),
        .rd_all     (rd_all)
    );

endmodule

// File: tb/tb_wb_port_scheduler.sv
// Randomized and directed check of wb_port_scheduler against a queue-based reference model.
module tb_wb_port_scheduler;
    import wb_pkg::*;

    localparam int DEPTH = WB_DEPTH;

    logic        clk = 1'b0;
    logic        reset;
    logic        RegWriteInA, RegWriteInB, LongValid;
    logic [4:0]  WriteRegInA, WriteRegInB, LongReg;
    logic [31:0] ResultInA, ResultInB, LongData;
    logic        LongReady, RegWriteOutA, RegWriteOutB;
    logic [4:0]  WriteRegOutA, WriteRegOutB;
    logic [31:0] ResultOutA, ResultOutB, PendingMask;
    logic [$clog2(DEPTH):0] PendingCount;

    int n_cmp  = 0;
    int n_fail = 0;

    wb_entry_t q[$];
    int        model_pops;

    always #5 clk = ~clk;

    wb_port_scheduler #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .RegWriteInA(RegWriteInA), .WriteRegInA(WriteRegInA), .ResultInA(ResultInA),
        .RegWriteInB(RegWriteInB), .WriteRegInB(WriteRegInB), .ResultInB(ResultInB),
        .LongValid(LongValid), .LongReady(LongReady), .LongReg(LongReg), .LongData(LongData),
        .RegWriteOutA(RegWriteOutA), .WriteRegOutA(WriteRegOutA), .ResultOutA(ResultOutA),
        .RegWriteOutB(RegWriteOutB), .WriteRegOutB(WriteRegOutB), .ResultOutB(ResultOutB),
        .PendingMask(PendingMask), .PendingCount(PendingCount)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_lanes(input logic wa, input logic [4:0] ra, input logic [31:0] da,
                             input logic wb, input logic [4:0] rb, input logic [31:0] db);
        RegWriteInA = wa; WriteRegInA = ra; ResultInA = da;
        RegWriteInB = wb; WriteRegInB = rb; ResultInB = db;
    endtask

    task automatic set_long(input logic v, input logic [4:0] r, input logic [31:0] d);
        LongValid = v; LongReg = r; LongData = d;
    endtask

    // Expected ports: lanes keep their port; idle ports take queue entries oldest first.
    task automatic model_check();
        logic        a_ok, b_ok, ea, eb;
        logic [4:0]  ra, rb;
        logic [31:0] da, db, mask;
        int          idx;
        b_ok = RegWriteInB && WriteRegInB != 5'd0;
        a_ok = RegWriteInA && WriteRegInA != 5'd0 && !(b_ok && WriteRegInB == WriteRegInA);
        idx = 0;
        ea = 1'b0; ra = '0; da = '0;
        eb = 1'b0; rb = '0; db = '0;
        if (a_ok) begin
            ea = 1'b1; ra = WriteRegInA; da = ResultInA;
        end else if (q.size() > idx) begin
            ea = q[idx].rd != 5'd0; ra = q[idx].rd; da = q[idx].data; idx++;
        end
        if (b_ok) begin
            eb = 1'b1; rb = WriteRegInB; db = ResultInB;
        end else if (q.size() > idx) begin
            eb = q[idx].rd != 5'd0; rb = q[idx].rd; db = q[idx].data; idx++;
        end
        model_pops = idx;
        mask = '0;
        foreach (q[i]) mask[q[i].rd] = 1'b1;
        check("en_a", 32'(RegWriteOutA), 32'(ea));
        if (ea) begin
            check("reg_a",  32'(WriteRegOutA), 32'(ra));
            check("data_a", ResultOutA, da);
        end
        check("en_b", 32'(RegWriteOutB), 32'(eb));
        if (eb) begin
            check("reg_b",  32'(WriteRegOutB), 32'(rb));
            check("data_b", ResultOutB, db);
        end
        check("long_ready", 32'(LongReady), 32'(q.size() < DEPTH));
        check("pending_count", 32'(PendingCount), 32'(q.size()));
        check("pending_mask", PendingMask, mask);
    endtask

    task automatic settle();
        @(negedge clk);
        model_check();
    endtask

    task automatic advance();
        logic accept;
        accept = LongValid && (q.size() < DEPTH);
        for (int i = 0; i < model_pops; i++) void'(q.pop_front());
        if (accept) q.push_back('{rd: LongReg, data: LongData});
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        set_lanes(0, 0, 0, 0, 0, 0);
        set_long(0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_en_a", 32'(RegWriteOutA), 0);
        check("rst_ready", 32'(LongReady), 0);
        check("rst_count", 32'(PendingCount), 0);
        check("rst_mask", PendingMask, 0);
        reset = 1'b0;

        // 1: single long op lands on port A the next cycle
        set_long(1, 5, 32'h11);
        settle(); check("t1_ready", 32'(LongReady), 1); advance();
        set_long(0, 0, 0);
        settle();
        check("t1_en_a", 32'(RegWriteOutA), 1);
        check("t1_reg_a", 32'(WriteRegOutA), 5);
        check("t1_data_a", ResultOutA, 32'h11);
        advance();
        settle(); check("t1_mask", PendingMask, 0); check("t1_count", 32'(PendingCount), 0); advance();

        // 2: busy lanes while filling the queue, then a double drain
        set_lanes(1, 1, 32'h101, 1, 2, 32'h202);
        for (int i = 0; i < DEPTH; i++) begin
            set_long(1, 5'(7 + i), 32'h700 + i);
            settle();
            check("t2_reg_a", 32'(WriteRegOutA), 1);
            check("t2_reg_b", 32'(WriteRegOutB), 2);
            advance();
        end
        set_long(0, 0, 0);
        settle(); check("t2_full_ready", 32'(LongReady), 0); advance();
        set_lanes(0, 0, 0, 0, 0, 0);
        settle();
        check("t2_reg_a", 32'(WriteRegOutA), 7);
        check("t2_reg_b", 32'(WriteRegOutB), 8);
        advance();

        // 3: lane A busy, head drains to B
        set_lanes(1, 3, 32'h333, 0, 0, 0);
        settle();
        check("t3_count", 32'(PendingCount), DEPTH - 2);
        check("t3_reg_a", 32'(WriteRegOutA), 3);
        check("t3_reg_b", 32'(WriteRegOutB), 9);
        advance();

        // 4: lane collision on r4, freed port A takes the head
        set_lanes(1, 4, 32'hAA, 1, 4, 32'hBB);
        settle();
        check("t4_reg_a", 32'(WriteRegOutA), 10);
        check("t4_data_a", ResultOutA, 32'h703);
        check("t4_data_b", ResultOutB, 32'hBB);
        advance();
        set_lanes(0, 0, 0, 0, 0, 0);
        settle(); advance();

        // 5: full queue, pop and offered push in one cycle
        set_lanes(1, 1, 32'h1, 1, 2, 32'h2);
        for (int i = 0; i < DEPTH; i++) begin
            set_long(1, 5'(11 + i), 32'hB00 + i);
            settle(); advance();
        end
        set_lanes(1, 1, 32'h1, 0, 0, 0);
        set_long(1, 20, 32'h2020);
        settle(); check("t5_ready", 32'(LongReady), 0); advance();
        set_long(0, 0, 0);
        settle(); check("t5_count", 32'(PendingCount), DEPTH - 1); advance();

        // Randomized traffic, many wrap-arounds
        for (int c = 0; c < 1500; c++) begin
            set_lanes($urandom_range(0, 1), 5'($urandom), $urandom,
                      $urandom_range(0, 1), 5'($urandom), $urandom);
            set_long($urandom_range(0, 2) != 0, 5'($urandom), $urandom);
            settle(); advance();
        end

        // 6: asynchronous reset with three entries pending
        set_lanes(0, 0, 0, 0, 0, 0);
        set_long(0, 0, 0);
        repeat (DEPTH) begin settle(); advance(); end
        set_lanes(1, 6, 32'h66, 1, 12, 32'hCC);
        for (int i = 0; i < 3; i++) begin
            set_long(1, 5'(21 + i), 32'hD00 + i);
            settle(); advance();
        end
        set_long(0, 0, 0);
        check("t6_pre_count", 32'(PendingCount), 3);
        #2 reset = 1'b1;
        #1;
        check("t6_en_a", 32'(RegWriteOutA), 0);
        check("t6_en_b", 32'(RegWriteOutB), 0);
        check("t6_ready", 32'(LongReady), 0);
        check("t6_count", 32'(PendingCount), 0);
        check("t6_mask", PendingMask, 0);
        q.delete();
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        set_lanes(0, 0, 0, 0, 0, 0);
        settle(); check("t6_post_en_a", 32'(RegWriteOutA), 0); advance();
        repeat (3) begin settle(); advance(); end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
